// File: rtl/sha_pkg.sv
// Shared types and helpers for the SHA-3 digest collector.
package sha_pkg;

  localparam int unsigned DIGEST_LEN_W = 10;

  typedef enum logic [1:0] {
    SHA3_224 = 2'b00,
    SHA3_256 = 2'b01,
    SHA3_384 = 2'b10,
    SHA3_512 = 2'b11
  } sha_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    DRAIN   = 2'b10,
    HOLD    = 2'b11
  } collector_state_e;

  // Digest length in bits for a SHA-3 variant.
  function automatic logic [DIGEST_LEN_W-1:0] digest_bits(input sha_mode_e mode);
    case (mode)
      SHA3_224: return 10'd224;
      SHA3_256: return 10'd256;
      SHA3_384: return 10'd384;
      SHA3_512: return 10'd512;
      default:  return 10'd512;
    endcase
  endfunction

endpackage

// File: rtl/sha_digest_collector_if.sv
// AXI-Stream beat bus from the SHA-3 output transmitter to the digest collector.
interface sha_digest_collector_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TVALID;
  logic                  TLAST;
  logic [1:0]            TUSER;
  logic                  TREADY;

  modport master (output TDATA, output TVALID, output TLAST, output TUSER, input  TREADY);
  modport slave  (input  TDATA, input  TVALID, input  TLAST, input  TUSER, output TREADY);
endinterface

// File: rtl/sha_digest_cmp.sv
// Registered digest-vs-expected comparator over the top len_i bits.
module sha_digest_cmp #(
  parameter int unsigned MAX_DIGEST_BITS = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_i,
  input  logic                       clear_i,
  input  logic [MAX_DIGEST_BITS-1:0] digest_i,
  input  logic [MAX_DIGEST_BITS-1:0] expected_i,
  input  logic [9:0]                 len_i,
  input  logic                       err_i,
  output logic                       match_o
);

  logic [MAX_DIGEST_BITS-1:0] mask_c;
  logic                       match_d, match_q;

  // Only the top len_i bits are meaningful; the rest of the digest is padding.
  assign mask_c = ~({MAX_DIGEST_BITS{1'b1}} >> len_i);

  always_comb begin
    match_d = match_q;
    if (load_i) begin
      match_d = (((digest_i ^ expected_i) & mask_c) == '0) && !err_i;
    end else if (clear_i) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/sha_digest_collector.sv
// Packs SHA-3 output beats MSB-first into a digest register and holds it until acked.
// Optional SHA_DIGEST_CMP_EN adds expected_i/match_o via sha_digest_cmp.
module sha_digest_collector
  import sha_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned MAX_DIGEST_BITS = 512
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  sha_digest_collector_if.slave      axis_s,
  output logic [MAX_DIGEST_BITS-1:0] digest_o,
  output logic [DIGEST_LEN_W-1:0]    digest_len_o,
  output logic                       digest_valid_o,
  input  logic                       digest_ack_i,
  output logic                       err_len_o
`ifdef SHA_DIGEST_CMP_EN
  ,
  input  logic [MAX_DIGEST_BITS-1:0] expected_i,
  output logic                       match_o
`endif
);

  localparam int unsigned SLOTS = MAX_DIGEST_BITS / DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);

  collector_state_e            state_q, state_d;
  sha_mode_e                   mode_q, mode_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [MAX_DIGEST_BITS-1:0]  digest_q, digest_d;
  logic [DIGEST_LEN_W-1:0]     len_q, len_d;
  logic                        err_q, err_d;
  logic                        valid_q, valid_d;
  logic                        tready_q, tready_d;

  logic                        fire_c;
  sha_mode_e                   beat_mode_c;
  logic [CNT_W-1:0]            n_beats_c;
  logic [CNT_W-1:0]            cnt_inc_c;

  assign fire_c      = axis_s.TVALID & tready_q;
  // TUSER only matters on the first beat of a packet.
  assign beat_mode_c = (state_q == IDLE) ? sha_mode_e'(axis_s.TUSER) : mode_q;
  assign n_beats_c   = CNT_W'(digest_bits(beat_mode_c) / DIGEST_LEN_W'(DATA_WIDTH));
  assign cnt_inc_c   = (cnt_q >= n_beats_c) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    digest_d = digest_q;
    len_d    = len_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (fire_c) begin
          mode_d   = beat_mode_c;
          len_d    = digest_bits(beat_mode_c);
          err_d    = 1'b0;
          digest_d = '0;
          digest_d[MAX_DIGEST_BITS-1 -: DATA_WIDTH] = axis_s.TDATA;
          cnt_d    = CNT_W'(1);
          if (axis_s.TLAST) begin
            state_d = HOLD;
            err_d   = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (fire_c) begin
          for (int unsigned s = 0; s < SLOTS; s++) begin
            if (cnt_q == CNT_W'(s)) begin
              digest_d[MAX_DIGEST_BITS-1-s*DATA_WIDTH -: DATA_WIDTH] = axis_s.TDATA;
            end
          end
          cnt_d = cnt_inc_c;
          if (axis_s.TLAST) begin
            state_d = HOLD;
            err_d   = (cnt_inc_c != n_beats_c);
          end else if (cnt_inc_c == n_beats_c) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fire_c && axis_s.TLAST) begin
          state_d = HOLD;
          err_d   = 1'b1;
        end
      end
      HOLD: begin
        if (digest_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d  = (state_d == HOLD);
    tready_d = (state_d != HOLD);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      mode_q   <= SHA3_224;
      cnt_q    <= '0;
      digest_q <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      digest_q <= digest_d;
      len_q    <= len_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      tready_q <= tready_d;
    end
  end

  assign axis_s.TREADY  = tready_q;
  assign digest_o       = digest_q;
  assign digest_len_o   = len_q;
  assign digest_valid_o = valid_q;
  assign err_len_o      = err_q;

`ifdef SHA_DIGEST_CMP_EN
  logic hold_enter_c, hold_leave_c;
  assign hold_enter_c = (state_d == HOLD) && (state_q != HOLD);
  assign hold_leave_c = (state_q == HOLD) && (state_d != HOLD);

  sha_digest_cmp #(
    .MAX_DIGEST_BITS(MAX_DIGEST_BITS)
  ) u_cmp (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .load_i    (hold_enter_c),
    .clear_i   (hold_leave_c),
    .digest_i  (digest_d),
    .expected_i(expected_i),
    .len_i     (len_d),
    .err_i     (err_d),
    .match_o   (match_o)
  );
`endif

endmodule

// File: tb/tb_sha_digest_collector.sv
// Directed self-checking bench for sha_digest_collector.
module tb_sha_digest_collector;
  import sha_pkg::*;

  localparam int unsigned DW   = 16;
  localparam int unsigned MAXB = 512;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha_digest_collector_if #(.DATA_WIDTH(DW)) axis ();

  logic [MAXB-1:0] digest;
  logic [9:0]      dlen;
  logic            dvalid;
  logic            ack;
  logic            err;
`ifdef SHA_DIGEST_CMP_EN
  logic [MAXB-1:0] expected;
  logic            match;
`endif

  sha_digest_collector #(.DATA_WIDTH(DW), .MAX_DIGEST_BITS(MAXB)) dut (
    .ACLK          (clk),
    .ARESETn       (rst_n),
    .axis_s        (axis),
    .digest_o      (digest),
    .digest_len_o  (dlen),
    .digest_valid_o(dvalid),
    .digest_ack_i  (ack),
    .err_len_o     (err)
`ifdef SHA_DIGEST_CMP_EN
    ,
    .expected_i    (expected),
    .match_o       (match)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [MAXB-1:0] model;

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [1:0] user,
                           input int gap);
    int k;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      axis.TVALID = 1'b0;
    end
    @(negedge clk);
    axis.TDATA  = d;
    axis.TLAST  = last;
    axis.TUSER  = user;
    axis.TVALID = 1'b1;
    k = 0;
    while (axis.TREADY !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (axis.TREADY !== 1'b1) begin
      total++; bad++;
      $display("FAIL beat_timeout: TREADY=%b required 1", axis.TREADY);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    axis.TVALID = 1'b0;
    axis.TLAST  = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (digest !== '0 || dlen !== 10'd0 || dvalid !== 1'b0 || err !== 1'b0 || axis.TREADY !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b len=%0d err=%b tready=%b required all 0",
               dvalid, dlen, err, axis.TREADY);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (axis.TREADY !== 1'b1) begin
      bad++; $display("FAIL reset_tready_release: got %b required 1", axis.TREADY);
    end
  endtask

  task automatic test_sha256();
    logic [DW-1:0] d;
    model = '0;
    for (int i = 0; i < 16; i++) begin
      d = DW'(i + 1);
      model[MAXB-1-DW*i -: DW] = d;
      send_beat(d, i == 15, 2'b01, 0);
    end
    bus_idle();
    total++;
    if (dvalid !== 1'b1 || axis.TREADY !== 1'b0) begin
      bad++; $display("FAIL s256_valid: valid=%b tready=%b required 1/0", dvalid, axis.TREADY);
    end
    total++;
    if (dlen !== 10'd256 || err !== 1'b0) begin
      bad++; $display("FAIL s256_len: len=%0d err=%b required 256/0", dlen, err);
    end
    total++;
    if (digest[511:496] !== 16'h0001 || digest[271:256] !== 16'h0010 || digest[255:0] !== '0) begin
      bad++; $display("FAIL s256_slots: first=%h last=%h low_nonzero=%b", digest[511:496],
                      digest[271:256], |digest[255:0]);
    end
    total++;
    if (digest !== model) begin
      bad++; $display("FAIL s256_digest: got %h required %h", digest, model);
    end
    do_ack();
    total++;
    if (dvalid !== 1'b0 || axis.TREADY !== 1'b1) begin
      bad++; $display("FAIL s256_ack: valid=%b tready=%b required 0/1", dvalid, axis.TREADY);
    end
  endtask

  task automatic test_drain_224();
    logic [DW-1:0] d;
    model = '0;
    for (int i = 0; i < 18; i++) begin
      d = DW'(16'hC000 + i);
      if (i < 14) model[MAXB-1-DW*i -: DW] = d;
      send_beat(d, i == 17, 2'b00, 0);
      if (i == 15) begin
        @(negedge clk);
        total++;
        if (dvalid !== 1'b0 || axis.TREADY !== 1'b1) begin
          bad++; $display("FAIL drain_accepting: valid=%b tready=%b required 0/1", dvalid, axis.TREADY);
        end
      end
    end
    bus_idle();
    total++;
    if (dvalid !== 1'b1 || err !== 1'b1 || dlen !== 10'd224) begin
      bad++; $display("FAIL drain_status: valid=%b err=%b len=%0d required 1/1/224", dvalid, err, dlen);
    end
    total++;
    if (digest !== model) begin
      bad++; $display("FAIL drain_digest: got %h required %h", digest, model);
    end
  endtask

  task automatic test_hold_stall();
    logic [MAXB-1:0] held;
    logic [DW-1:0]   d;
    held = model;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      axis.TVALID = 1'b1;
      axis.TDATA  = 16'hFFFF;
      axis.TLAST  = (c == 9);
      #1;
      total++;
      if (axis.TREADY !== 1'b0 || dvalid !== 1'b1 || digest !== held) begin
        bad++; $display("FAIL hold_stall_%0d: tready=%b valid=%b required 0/1 digest_same=%b",
                        c, axis.TREADY, dvalid, digest === held);
      end
    end
    bus_idle();
    do_ack();
    total++;
    if (dvalid !== 1'b0 || axis.TREADY !== 1'b1 || digest !== held) begin
      bad++; $display("FAIL hold_release: valid=%b tready=%b required 0/1 digest_same=%b",
                      dvalid, axis.TREADY, digest === held);
    end
    // Next packet; ack held high from mid-COLLECT through entry to HOLD.
    model = '0;
    for (int i = 0; i < 16; i++) begin
      d = DW'(16'h1100 + i);
      model[MAXB-1-DW*i -: DW] = d;
      if (i == 9) ack = 1'b1;
      send_beat(d, i == 15, 2'b01, 0);
    end
    bus_idle();
    total++;
    if (dvalid !== 1'b1 || err !== 1'b0 || dlen !== 10'd256 || digest !== model) begin
      bad++; $display("FAIL next_packet: valid=%b err=%b len=%0d required 1/0/256 digest_ok=%b",
                      dvalid, err, dlen, digest === model);
    end
    @(negedge clk);
    ack = 1'b0;
    total++;
    if (dvalid !== 1'b0 || axis.TREADY !== 1'b1) begin
      bad++; $display("FAIL ack_on_entry: valid=%b tready=%b required 0/1", dvalid, axis.TREADY);
    end
  endtask

  task automatic send_384(input logic [DW-1:0] base);
    logic [DW-1:0] d;
    model = '0;
    for (int i = 0; i < 24; i++) begin
      d = base + DW'(i);
      model[MAXB-1-DW*i -: DW] = d;
    end
`ifdef SHA_DIGEST_CMP_EN
    expected = model;
`endif
    for (int i = 0; i < 24; i++) begin
      d = base + DW'(i);
      send_beat(d, i == 23, 2'b10, 0);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) send_beat(DW'(16'h3000 + i), 1'b0, 2'b10, 0);
    @(negedge clk);
    axis.TVALID = 1'b1;
    axis.TDATA  = 16'h3006;
    rst_n       = 1'b0;
    #1;
    total++;
    if (digest !== '0 || dvalid !== 1'b0 || dlen !== 10'd0 || err !== 1'b0 || axis.TREADY !== 1'b0) begin
      bad++; $display("FAIL reset_mid: valid=%b len=%0d err=%b tready=%b required all 0",
                      dvalid, dlen, err, axis.TREADY);
    end
    @(negedge clk);
    axis.TVALID = 1'b0;
    rst_n       = 1'b1;
    send_384(16'h4000);
    total++;
    if (dvalid !== 1'b1 || err !== 1'b0 || dlen !== 10'd384 || digest !== model) begin
      bad++; $display("FAIL s384_after_reset: valid=%b err=%b len=%0d required 1/0/384 digest_ok=%b",
                      dvalid, err, dlen, digest === model);
    end
    total++;
    if (digest[127:0] !== '0 || digest[511:496] !== 16'h4000 || digest[143:128] !== 16'h4017) begin
      bad++; $display("FAIL s384_slots: first=%h last=%h", digest[511:496], digest[143:128]);
    end
`ifdef SHA_DIGEST_CMP_EN
    total++;
    if (match !== 1'b1) begin
      bad++; $display("FAIL match_equal: got %b required 1", match);
    end
`endif
    do_ack();
`ifdef SHA_DIGEST_CMP_EN
    total++;
    if (match !== 1'b0) begin
      bad++; $display("FAIL match_clear: got %b required 0", match);
    end
    model = '0;
    for (int i = 0; i < 24; i++) model[MAXB-1-DW*i -: DW] = DW'(16'h4000 + i);
    for (int i = 0; i < 24; i++) send_beat(DW'(16'h4000 + i), i == 23, 2'b10, 0);
    bus_idle();
    total++;
    if (match !== 1'b1) begin
      bad++; $display("FAIL match_repeat: got %b required 1", match);
    end
    do_ack();
    expected = model;
    expected[400] = ~expected[400];
    for (int i = 0; i < 24; i++) send_beat(DW'(16'h4000 + i), i == 23, 2'b10, 0);
    bus_idle();
    total++;
    if (match !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL match_flipped: match=%b err=%b required 0/0", match, err);
    end
    do_ack();
`endif
  endtask

  task automatic test_short_512();
    logic [DW-1:0] d;
    model = '0;
    for (int i = 0; i < 20; i++) begin
      d = DW'(16'h5000 + i);
      model[MAXB-1-DW*i -: DW] = d;
      send_beat(d, i == 19, 2'b11, 0);
    end
    bus_idle();
    total++;
    if (dvalid !== 1'b1 || err !== 1'b1 || dlen !== 10'd512 || axis.TREADY !== 1'b0) begin
      bad++; $display("FAIL short512_status: valid=%b err=%b len=%0d tready=%b required 1/1/512/0",
                      dvalid, err, dlen, axis.TREADY);
    end
    total++;
    if (digest[191:0] !== '0 || digest !== model) begin
      bad++; $display("FAIL short512_digest: got %h required %h", digest, model);
    end
    do_ack();
  endtask

  task automatic test_gaps_224();
    int            gaps [14] = '{0, 2, 0, 1, 3, 0, 0, 1, 0, 4, 0, 1, 0, 2};
    logic [1:0]    user;
    logic [DW-1:0] d;
    model = '0;
    for (int i = 0; i < 14; i++) begin
      d = DW'(16'hA000 + 16'h0101 * i);
      model[MAXB-1-DW*i -: DW] = d;
      user = (i == 0) ? 2'b00 : ((i % 2) == 1 ? 2'b11 : 2'b01);
      send_beat(d, i == 13, user, gaps[i]);
    end
    bus_idle();
    total++;
    if (dvalid !== 1'b1 || err !== 1'b0 || dlen !== 10'd224) begin
      bad++; $display("FAIL gaps224_status: valid=%b err=%b len=%0d required 1/0/224", dvalid, err, dlen);
    end
    total++;
    if (digest[287:0] !== '0 || digest !== model) begin
      bad++; $display("FAIL gaps224_digest: got %h required %h", digest, model);
    end
    do_ack();
  endtask

  initial begin
    axis.TVALID = 1'b0;
    axis.TLAST  = 1'b0;
    axis.TDATA  = '0;
    axis.TUSER  = 2'b00;
    ack         = 1'b0;
`ifdef SHA_DIGEST_CMP_EN
    expected    = '0;
`endif
    test_reset();
    test_sha256();
    test_drain_224();
    test_hold_stall();
    test_reset_mid();
    test_short_512();
    test_gaps_224();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
